// File: rtl/vga_pkg.sv
// Shared video timing definitions for the VGA timing generator.
// Holds the default 640x480@60 timing, sync polarities, colour depth,
// the delay-tap record and a helper that sums a timing axis.
package vga_pkg;

  localparam int unsigned CoordW   = 11;
  localparam int unsigned MaxTotal = 2048;

  // 640x480@60 with a 25.175 MHz pixel clock
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  // 0 = active-low sync pulse
  localparam bit DefHsPol = 1'b0;
  localparam bit DefVsPol = 1'b0;

  localparam int unsigned DefColorBits = 4;
  localparam int unsigned MaxPixLat    = 4;

  // One tap of the alignment pipe
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } tap_t;

  localparam int unsigned TapW = $bits(tap_t);

  function automatic int unsigned timing_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register used to align blanking/sync with the
// drawing pipeline. Depth 0 degenerates to a wire.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, loads ResetVal into every tap
//   en   - shift enable; taps hold when low
//   d    - input word
//   q    - word delayed by Depth enabled cycles
module vga_delay_line #(
  parameter int unsigned Width        = 1,
  parameter int unsigned Depth        = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (Depth == 0) begin : gen_bypass
    assign q = d;
  end else begin : gen_taps
    logic [Width-1:0] taps_q [Depth];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(Depth); i++) taps_q[i] <= ResetVal;
      end else if (en) begin
        taps_q[0] <= d;
        for (int i = 1; i < int'(Depth); i++) taps_q[i] <= taps_q[i-1];
      end
    end

    assign q = taps_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and output stage.
// Scans x/y for the drawing module, delays blanking/sync by PIX_LAT enabled
// cycles to meet pix_in coming back, then registers RGB and sync at the pins.
// Ports:
//   clk, rst, en        - pixel clock, sync active-high reset, clock enable
//   pix_in              - {R,G,B} from drawing module, PIX_LAT cycles after x/y
//   x, y                - scan coordinates
//   active              - x/y lie in the visible area
//   frame_start         - x=0 and y=0
//   line_start          - x=0
//   red, green, blue    - blanked colour outputs
//   hsync, vsync        - sync pins at configured polarity
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter bit          HS_POL     = DefHsPol,
  parameter bit          VS_POL     = DefVsPol,
  parameter int unsigned COLOR_BITS = DefColorBits,
  parameter int unsigned PIX_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [3*COLOR_BITS-1:0] pix_in,
  output logic [CoordW-1:0]       x,
  output logic [CoordW-1:0]       y,
  output logic                    active,
  output logic                    frame_start,
  output logic                    line_start,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    hsync,
  output logic                    vsync
);

  localparam int unsigned HTotal = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (HTotal > MaxTotal || VTotal > MaxTotal) begin : gen_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2048");
  end
  if (PIX_LAT > MaxPixLat) begin : gen_lat_check
    $error("vga_timing_gen: PIX_LAT must be 0..4");
  end

  localparam logic [CoordW-1:0] HLast = CoordW'(HTotal - 1);
  localparam logic [CoordW-1:0] VLast = CoordW'(VTotal - 1);

  // Decode bounds kept one bit wider so an end bound of 2048 does not wrap
  localparam logic [CoordW:0] HAct    = (CoordW+1)'(H_ACTIVE);
  localparam logic [CoordW:0] VAct    = (CoordW+1)'(V_ACTIVE);
  localparam logic [CoordW:0] HsStart = (CoordW+1)'(H_ACTIVE + H_FP);
  localparam logic [CoordW:0] HsEnd   = (CoordW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CoordW:0] VsStart = (CoordW+1)'(V_ACTIVE + V_FP);
  localparam logic [CoordW:0] VsEnd   = (CoordW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CoordW-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == HLast) begin
      x_d = '0;
      y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic [CoordW:0] x_w, y_w;
  assign x_w = {1'b0, x_q};
  assign y_w = {1'b0, y_q};

  assign x           = x_q;
  assign y           = y_q;
  assign active      = (x_w < HAct) && (y_w < VAct);
  assign line_start  = (x_q == '0);
  assign frame_start = (x_q == '0) && (y_q == '0);

  tap_t raw, dly;
  assign raw.active = active;
  assign raw.hsync  = (x_w >= HsStart) && (x_w < HsEnd);
  assign raw.vsync  = (y_w >= VsStart) && (y_w < VsEnd);

  logic [TapW-1:0] dly_bits;

  vga_delay_line #(
    .Width    (TapW),
    .Depth    (PIX_LAT),
    .ResetVal ('0)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (raw),
    .q   (dly_bits)
  );

  assign dly = tap_t'(dly_bits);

  logic [3*COLOR_BITS-1:0] rgb_q;
  logic                    hsync_q, vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
    end else if (en) begin
      rgb_q   <= dly.active ? pix_in : '0;
      hsync_q <= dly.hsync ? HS_POL : ~HS_POL;
      vsync_q <= dly.vsync ? VS_POL : ~VS_POL;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync              = hsync_q;
  assign vsync              = vsync_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised video timing generator and output stage, successor to the fixed 640x480 sync block. Produces the pixel scan coordinates (x, y) for the drawing module, aligns sync/blanking to a drawing pipeline of configurable latency, and drives the blanked RGB pins at configurable colour depth. Sits between the pixel clock (25.175 MHz) and the VGA connector; the drawing module consumes x/y and returns pix_in PIX_LAT cycles later.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
COLOR_BITS, 4, bits per colour channel
PIX_LAT, 1, drawing-pipeline latency in cycles from x/y to pix_in; legal 0..4

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  pixel clock enable; 0 freezes all state
pix_in  in  3*COLOR_BITS  {R,G,B} from drawing module, R in MSBs
x  out  11  current horizontal count (0..H_TOTAL-1)
y  out  11  current vertical count (0..V_TOTAL-1)
active  out  1  x<H_ACTIVE and y<V_ACTIVE, aligned with x/y
frame_start  out  1  one-cycle pulse when x=0,y=0
line_start  out  1  one-cycle pulse when x=0
red  out  COLOR_BITS  output red, zero when blanked
green  out  COLOR_BITS  output green, zero when blanked
blue  out  COLOR_BITS  output blue, zero when blanked
hsync  out  1  horizontal sync at pin
vsync  out  1  vertical sync at pin

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both must be <=2048 (elaboration check).
- Reset (rst=1 at clk edge): x=0, y=0, all delay taps cleared to blank/inactive; red/green/blue=0; hsync=~HS_POL, vsync=~VS_POL; frame_start=0, line_start=0. Reset takes effect regardless of en.
- Counters advance only when en=1: x increments; at x=H_TOTAL-1, x wraps to 0 and y increments; at y=V_TOTAL-1 with x wrap, y wraps to 0.
- x, y, active, frame_start, line_start are registered-state outputs decoded from counters (same cycle as counts); frame_start first asserts on the first en cycle after reset release is NOT required (counters already at 0 -> asserts immediately while x=0,y=0).
- Raw hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; vsync changes on line boundaries only.
- Alignment: raw active/hsync/vsync pass through a PIX_LAT-deep shift register (advancing only on en), then one output register stage together with pix_in. Total latency x/y -> pins = PIX_LAT+1 enabled cycles.
- RGB output register: {red,green,blue} <= delayed_active ? pix_in : 0.
- Sync pins: hsync <= delayed_hs ? HS_POL : ~HS_POL; same for vsync.
- en=0: every register holds; pins hold last value.
- PIX_LAT=0: shift register absent; pix_in combinationally from x/y is sampled in same cycle.

Decomposition:
- Shared package vga_pkg: default 640x480@60 timing constants, polarity constants, COLOR_BITS default, H_TOTAL/V_TOTAL helper function.
- One sub-module: vga_delay_line (width W, depth D, clock-enabled shift register with synchronous reset value parameter), used for the active/hsync/vsync alignment pipe.

Test Plan:
- Reset then en=1 for 420000 cycles (defaults) -> x wraps after 800 cycles, y after 525 lines; frame_start exactly once per 420000 cycles, line_start every 800.
- Default timing, PIX_LAT=1 -> hsync low for exactly 96 cycles starting 658 cycles after line_start (656+2 latency); vsync low for 2 lines (1600 cycles) starting at line 490 (+2 cycles).
- pix_in=12'hFFF constant, PIX_LAT=2 -> red/green/blue=4'hF for 640 consecutive cycles starting 3 cycles after x=0 on lines 0..479; 0 for remaining 160 cycles and on lines 480..524.
- en toggling 1/0 every cycle -> all waveforms identical to en=1 case when sampled on en=1 cycles; outputs hold during en=0.
- Assert rst mid-line (x=300,y=200) for 1 cycle -> next cycle x=0,y=0, rgb=0, hsync=vsync=1, frame_start=1.
- Override H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1,HS_POL=1,COLOR_BITS=8 -> 14-cycle lines, 7-line frames, hsync high at x=10..11 (+latency), 24-bit RGB passes through.
